serial_out_port: RTL
====================

// Module: serial_out_port
// PURPOSE
//  Memory-mapped serial output device on the CPU's store path, downstream of the core.
//  Captures bytes stored to DATA_ADDR, queues them in a small FIFO and shifts each out
//  as an 8N1 frame on a single tx line, so sim programs can emit characters.
//  Sits beside the memory block on the same abus/dbus/storeMem/assertM signals.
// PARAMETERS
//  DATA_ADDR     8'hFE  abus value selecting the transmit-data register (write-only)
//  STATUS_ADDR   8'hFF  abus value selecting the status register (read, see CONFIGURATION)
//  DEPTH         4      FIFO entries; power of two, 2..16
//  CLKS_PER_BIT  4      clk cycles per serial bit, >=1
// PORTS
//  clk         in   1  system clock; all state changes on posedge
//  reset       in   1  synchronous, active-high
//  storeMem    in   1  CPU store strobe, sampled on posedge
//  assertM     in   1  CPU memory-read strobe
//  abus        in   8  CPU address bus
//  dbus_in     in   8  CPU data bus value, sampled on store
//  status_out  out  8  status byte for the CPU to drive onto dbus
//  status_oe   out  1  high when status_out must be driven onto dbus (top-level tristate)
//  tx          out  1  serial line, idle high
//  busy        out  1  frame in progress or FIFO non-empty
//  full        out  1  FIFO holds DEPTH entries
//  overflow    out  1  sticky: a write was dropped because FIFO was full
// BEHAVIOUR
//  - Reset (reset=1 at posedge): FIFO emptied, FSM->IDLE, tx=1, busy=0, full=0,
//    overflow=0, bit/clock counters 0. Mid-frame reset aborts the frame; tx=1 next edge.
//  - Write accept: posedge with storeMem=1 && abus==DATA_ADDR. If !full (value before
//    this edge), dbus_in pushed. If full, byte dropped, overflow<=1. Write vs pop same edge:
//    full judged pre-edge, so a write to a full FIFO is dropped even if a pop occurs.
//  - Stores to any other address ignored; assertM alone never changes state.
//  - FSM: IDLE -> START when FIFO non-empty (pop head into shift reg on that edge);
//    START (tx=0, CLKS_PER_BIT cycles) -> DATA (8 bits LSB first, CLKS_PER_BIT each)
//    -> STOP (tx=1, CLKS_PER_BIT cycles) -> START if FIFO non-empty else IDLE.
//    Back-to-back frames have no idle gap beyond the stop bit.
//  - Latency: write at edge N into empty FIFO, IDLE -> START at edge N+1, tx=0 after N+1.
//    Frame = 10*CLKS_PER_BIT cycles.
//  - tx is registered; no glitches. busy = (state!=IDLE) || !empty.
//  - FIFO: circular, pointer width clog2(DEPTH)+1; pointers wrap silently.
//  - overflow cleared only by reset.
// CONFIGURATION
//  STATUS_READ_EN defined: status_oe = assertM && (abus==STATUS_ADDR) (combinational);
//   status_out = {overflow,4'b0,busy,full,empty}. Reading has no side effects.
//  STATUS_READ_EN undefined: status_oe=0, status_out=8'h00 constantly; overflow/full/busy
//   ports still present and functional.
// TESTING (DEPTH=4, CLKS_PER_BIT=4)
//  1 Store 8'hA5 to 8'hFE once -> tx from next edge: 0,1,0,1,0,0,1,0,1,1 each held
//    4 cycles (40 cycles); busy falls at frame end; tx stays 1.
//  2 Stores bytes 1..6 on 6 consecutive edges -> bytes 1..5 sent in order back-to-back,
//    byte 6 dropped, overflow=1, full seen high after edge 5.
//  3 Store 8'h33 to 8'h10, and assertM at 8'hFE -> no tx activity, busy=0, overflow=0.
//  4 Reset asserted at cycle 15 of a frame with 2 queued bytes -> tx=1, busy=0,
//    full=0 next edge; no further frames emitted.
//  5 With STATUS_READ_EN: assertM, abus=8'hFF while 4 queued + overflow -> status_oe=1,
//    status_out=8'h86; without macro -> status_oe=0, status_out=8'h00.

Source files
------------

// File: rtl/serial_out_port.sv
// Memory-mapped 8N1 serial transmitter: stores to DATA_ADDR are queued in a small FIFO
// and shifted out on tx. Optional status register read path enabled by STATUS_READ_EN.
module serial_out_port #(
  parameter logic [7:0] DATA_ADDR    = 8'hFE,
  parameter logic [7:0] STATUS_ADDR  = 8'hFF,
  parameter int         DEPTH        = 4,
  parameter int         CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       storeMem,
  input  logic       assertM,
  input  logic [7:0] abus,
  input  logic [7:0] dbus_in,
  output logic [7:0] status_out,
  output logic       status_oe,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT         state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [CW-1:0] clkCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          empty;
  logic          bitDone;
  logic          dataWrite;
  logic          push;
  logic          pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty     = (wrPtr == rdPtr);
  assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign bitDone   = (clkCnt == LAST_CLK);
  assign dataWrite = storeMem && (abus == DATA_ADDR);
  assign push      = dataWrite && !full;
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && bitDone));
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      if (dataWrite && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr[AW-1:0]] <= dbus_in;
  end

  // Shift register holds the not-yet-sent bits; tx is always driven from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tx     <= 1'b1;
      clkCnt <= '0;
      bitCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state    <= START;
            tx       <= 1'b0;
            clkCnt   <= '0;
            shiftReg <= mem[rdPtr[AW-1:0]];
          end
        end
        START: begin
          if (bitDone) begin
            state    <= DATA;
            tx       <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            clkCnt   <= '0;
            bitCnt   <= '0;
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitDone) begin
            clkCnt <= '0;
            if (bitCnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              tx       <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitDone) begin
            clkCnt <= '0;
            // Chain straight into the next start bit so frames run back-to-back.
            if (!empty) begin
              state    <= START;
              tx       <= 1'b0;
              shiftReg <= mem[rdPtr[AW-1:0]];
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            clkCnt <= clkCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

`ifdef STATUS_READ_EN
  assign status_oe  = assertM && (abus == STATUS_ADDR);
  assign status_out = {overflow, 4'b0000, busy, full, empty};
`else
  logic unusedStatusIn;
  assign unusedStatusIn = &{1'b0, assertM};
  assign status_oe      = 1'b0;
  assign status_out     = 8'h00;
`endif

endmodule
